// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and default parameters for the main-lane data-memory access controller.
package mem_access_ctrl_pkg;

  localparam int XLEN_DEF    = 64;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_AMO_WREQ,
    ST_AMO_WRESP,
    ST_DONE
  } memc_state_e;

  // States in which the controller is waiting on the bus and the timeout runs.
  function automatic logic is_wait_state(input memc_state_e s);
    return (s == ST_REQ) || (s == ST_RESP) || (s == ST_AMO_WREQ) || (s == ST_AMO_WRESP);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/grant/response bus between the access controller and the D-cache/device bus.
interface mem_access_ctrl_if
  import mem_access_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_cacheable;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_cacheable, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_cacheable, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// Wait-state timeout counter: cleared on state entry, counts while enabled,
// flags expiry on the TIMEOUT-th consecutive waiting cycle.
module mem_access_ctrl_timeout_cnt
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences load, store and AMO read-modify-write accesses for the instruction in EX/MEM,
// stalling the pipeline until the access completes, is cancelled or times out.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_mem_valid,
  input  logic              i_mem_is_load,
  input  logic              i_mem_is_store,
  input  logic              i_mem_is_amo,
  input  logic              i_mem_is_fail_sc,
  input  logic              i_mem_is_cache_mem,
  input  logic [XLEN-1:0]   i_mem_addr,
  input  logic [XLEN-1:0]   i_mem_wdata,
  input  logic [XLEN-1:0]   i_amo_wdata,
  input  logic              i_flush_mem,
  mem_access_ctrl_if.master bus,
  output logic              o_hold,
  output logic [XLEN-1:0]   o_load_data,
  output logic              o_load_valid,
  output logic              o_bus_err
);

  memc_state_e     r_state;
  logic            r_req;
  logic            r_we;
  logic            r_cacheable;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_hold;
  logic [XLEN-1:0] r_load_data;
  logic            r_load_valid;
  logic            r_bus_err;
  logic            r_killed;
  logic            r_amo;
  logic            r_rd;

  logic w_start;
  logic w_kill;
  logic w_wait;
  logic w_leave;
  logic w_expired;

  assign w_start = i_mem_valid && (i_mem_is_load || i_mem_is_store || i_mem_is_amo)
                   && !i_mem_is_fail_sc && !i_flush_mem;
  assign w_kill  = r_killed || i_flush_mem;
  assign w_wait  = is_wait_state(r_state);

  always_comb begin
    w_leave = 1'b0;
    case (r_state)
      ST_REQ:                w_leave = bus.dmem_gnt || i_flush_mem || w_expired;
      ST_RESP, ST_AMO_WRESP: w_leave = bus.dmem_rvalid || w_expired;
      ST_AMO_WREQ:           w_leave = bus.dmem_gnt || w_expired;
      default:               w_leave = 1'b0;
    endcase
  end

  mem_access_ctrl_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk       (clk),
    .rstn      (rstn),
    .i_clear   (w_leave || !w_wait),
    .i_enable  (w_wait),
    .o_expired (w_expired)
  );

  // A flush seen while waiting is remembered so the result is dropped at DONE.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state      <= ST_IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_cacheable  <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_hold       <= 1'b0;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      r_killed     <= 1'b0;
      r_amo        <= 1'b0;
      r_rd         <= 1'b0;
    end else begin
      r_load_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      if (w_wait) begin
        r_killed <= w_kill;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_REQ;
            r_req       <= 1'b1;
            r_hold      <= 1'b1;
            r_we        <= i_mem_is_store;
            r_cacheable <= i_mem_is_cache_mem;
            r_addr      <= i_mem_addr;
            r_wdata     <= i_mem_wdata;
            r_amo       <= i_mem_is_amo;
            r_rd        <= i_mem_is_load || i_mem_is_amo;
            r_killed    <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bus.dmem_gnt) begin
            r_state <= ST_RESP;
            r_req   <= 1'b0;
          end else if (i_flush_mem) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_hold  <= 1'b0;
          end else if (w_expired) begin
            r_state     <= ST_DONE;
            r_req       <= 1'b0;
            r_hold      <= 1'b0;
            r_bus_err   <= 1'b1;
            r_load_data <= '0;
          end
        end
        ST_RESP: begin
          if (bus.dmem_rvalid) begin
            r_load_data <= bus.dmem_rdata;
            if (r_amo && !w_kill) begin
              r_state <= ST_AMO_WREQ;
              r_req   <= 1'b1;
              r_we    <= 1'b1;
            end else begin
              r_state      <= ST_DONE;
              r_hold       <= 1'b0;
              r_load_valid <= r_rd && !w_kill;
            end
          end else if (w_expired) begin
            r_state     <= ST_DONE;
            r_hold      <= 1'b0;
            r_bus_err   <= 1'b1;
            r_load_data <= '0;
          end
        end
        ST_AMO_WREQ: begin
          if (bus.dmem_gnt) begin
            r_state <= ST_AMO_WRESP;
            r_req   <= 1'b0;
          end else if (w_expired) begin
            r_state     <= ST_DONE;
            r_req       <= 1'b0;
            r_hold      <= 1'b0;
            r_bus_err   <= 1'b1;
            r_load_data <= '0;
          end
        end
        ST_AMO_WRESP: begin
          if (bus.dmem_rvalid) begin
            r_state      <= ST_DONE;
            r_hold       <= 1'b0;
            r_load_valid <= r_rd && !w_kill;
          end else if (w_expired) begin
            r_state     <= ST_DONE;
            r_hold      <= 1'b0;
            r_bus_err   <= 1'b1;
            r_load_data <= '0;
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_killed <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The AMO result is derived from load_data, so it is passed through live during the write request.
  assign bus.dmem_req       = r_req;
  assign bus.dmem_we        = r_we;
  assign bus.dmem_cacheable = r_cacheable;
  assign bus.dmem_addr      = r_addr;
  assign bus.dmem_wdata     = (r_state == ST_AMO_WREQ) ? i_amo_wdata : r_wdata;

  // rstn is active-high; hold is forced low while reset is applied.
  assign o_hold       = !rstn && (r_hold || ((r_state == ST_IDLE) && w_start));
  assign o_load_data  = r_load_data;
  assign o_load_valid = r_load_valid;
  assign o_bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a bus responder with random grant/response delays,
// with every instruction checked against a transaction-level model of the expected outcome.
module tb_mem_access_ctrl;

  localparam int XLEN     = 64;
  localparam int TIMEOUT  = 255;
  localparam int NEVER    = 100000;
  localparam int K_LOAD   = 0;
  localparam int K_STORE  = 1;
  localparam int K_AMO    = 2;
  localparam int K_FAILSC = 3;

  logic            clk = 1'b0;
  logic            rstn;
  logic            memValid, isLoad, isStore, isAmo, isFailSc, isCacheMem, flushMem;
  logic [XLEN-1:0] memAddr, memWdata, amoWdata, loadData;
  logic            hold, loadValid, busErr;
  int              vecCount = 0;
  int              missCount = 0;

  mem_access_ctrl_if #(.XLEN(XLEN)) bus ();

  mem_access_ctrl #(
    .XLEN    (XLEN),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .i_mem_valid        (memValid),
    .i_mem_is_load      (isLoad),
    .i_mem_is_store     (isStore),
    .i_mem_is_amo       (isAmo),
    .i_mem_is_fail_sc   (isFailSc),
    .i_mem_is_cache_mem (isCacheMem),
    .i_mem_addr         (memAddr),
    .i_mem_wdata        (memWdata),
    .i_amo_wdata        (amoWdata),
    .i_flush_mem        (flushMem),
    .bus                (bus),
    .o_hold             (hold),
    .o_load_data        (loadData),
    .o_load_valid       (loadValid),
    .o_bus_err          (busErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Hold cycles of an unflushed instruction: one IDLE cycle, then grant wait plus response wait per phase.
  function automatic int expHoldOf(input int kind, input int gDly, input int rDly);
    int ph;
    ph = (gDly + 1) + (rDly + 1);
    if (kind == K_FAILSC) return 0;
    if (gDly >= TIMEOUT) return 1 + TIMEOUT;
    return 1 + ph + ((kind == K_AMO) ? ph : 0);
  endfunction

  // Runs one instruction; cycle 0 is its IDLE cycle, fAt is the cycle carrying a flush (-1 for none).
  task automatic applyStimulus(input string name, input int kind, input logic cach,
                               input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wd,
                               input logic [XLEN-1:0] awd, input logic [XLEN-1:0] rd,
                               input int gDly, input int rDly, input int fAt);
    int gntCyc, rdCyc, expHold, expGnt, expReq;
    bit noGnt, flushEarly, killed, skipW, expLv, expBe;
    int holdCnt, gntCnt, reqCnt, lvCnt, beCnt, lvAt, beAt, unstable, reqCyc, rspWait, rspCnt;
    logic [XLEN-1:0] lvData, beData, prevAddr, prevWd;
    logic [XLEN-1:0] gAddr[4];
    logic [XLEN-1:0] gWd[4];
    logic gWe[4];
    logic gCach[4];
    bit prevReq, doneSeen, flushed, rv, gt;

    gntCyc = 1 + gDly;
    rdCyc = gntCyc + 1 + rDly;
    noGnt = (kind != K_FAILSC) && (gDly >= TIMEOUT);
    flushEarly = (fAt > 0) && (fAt < gntCyc) && !noGnt;
    killed = (fAt > 0) && !flushEarly;
    skipW = (kind == K_AMO) && killed && (fAt <= rdCyc);
    if (kind == K_FAILSC) begin
      expHold = 0; expGnt = 0; expReq = 0; expLv = 0; expBe = 0;
    end else if (noGnt) begin
      expHold = 1 + TIMEOUT; expGnt = 0; expReq = TIMEOUT; expLv = 0; expBe = 1;
    end else if (flushEarly) begin
      expHold = fAt + 1; expGnt = 0; expReq = fAt; expLv = 0; expBe = 0;
    end else begin
      expGnt = ((kind == K_AMO) && !skipW) ? 2 : 1;
      expHold = 1 + ((gDly + 1) + (rDly + 1)) * expGnt;
      expReq = (gDly + 1) * expGnt;
      expLv = (kind != K_STORE) && !killed;
      expBe = 0;
    end

    holdCnt = 0; gntCnt = 0; reqCnt = 0; lvCnt = 0; beCnt = 0; lvAt = -1; beAt = -1;
    unstable = 0; reqCyc = 0; rspWait = 0; rspCnt = 0;
    lvData = '0; beData = '1; prevAddr = '0; prevWd = '0;
    prevReq = 0; doneSeen = 0; flushed = 0;

    for (int cyc = 0; cyc < 2 * TIMEOUT + 100 && !doneSeen; cyc++) begin
      @(negedge clk);
      if (cyc == fAt) flushed = 1;
      flushMem   = (cyc == fAt);
      memValid   = !flushed;
      isLoad     = (kind == K_LOAD);
      isStore    = (kind == K_STORE) || (kind == K_FAILSC);
      isAmo      = (kind == K_AMO);
      isFailSc   = (kind == K_FAILSC);
      isCacheMem = cach;
      memAddr    = addr;
      memWdata   = wd;
      amoWdata   = awd;

      rv = 1'b0;
      if (rspWait > 0) begin
        rspWait--;
        rv = (rspWait == 0);
      end
      bus.dmem_rvalid = rv;
      bus.dmem_rdata  = (rv && rspCnt == 0) ? rd : {$urandom, $urandom};
      if (rv) rspCnt++;

      gt = 1'b0;
      if (bus.dmem_req) begin
        reqCnt++;
        if (prevReq && (bus.dmem_addr !== prevAddr || bus.dmem_wdata !== prevWd)) unstable++;
        if (reqCyc == gDly) begin
          gt = 1'b1;
          reqCyc = 0;
          rspWait = rDly + 1;
          if (gntCnt < 4) begin
            gAddr[gntCnt] = bus.dmem_addr;
            gWd[gntCnt]   = bus.dmem_wdata;
            gWe[gntCnt]   = bus.dmem_we;
            gCach[gntCnt] = bus.dmem_cacheable;
          end
          gntCnt++;
        end else begin
          reqCyc++;
        end
      end else begin
        reqCyc = 0;
      end
      prevReq  = bus.dmem_req;
      prevAddr = bus.dmem_addr;
      prevWd   = bus.dmem_wdata;
      bus.dmem_gnt = gt;

      #1;
      if (hold) holdCnt++;
      else if (cyc > 0) doneSeen = 1;
      if (loadValid) begin
        lvCnt++; lvData = loadData; lvAt = cyc;
      end
      if (busErr) begin
        beCnt++; beData = loadData; beAt = cyc;
      end
    end
    bus.dmem_gnt = 1'b0;
    bus.dmem_rvalid = 1'b0;
    flushMem = 1'b0;

    checkOutput({name, ".finished"},   64'(doneSeen), 64'd1);
    checkOutput({name, ".holdCycles"}, 64'(holdCnt),  64'(expHold));
    checkOutput({name, ".grants"},     64'(gntCnt),   64'(expGnt));
    checkOutput({name, ".reqCycles"},  64'(reqCnt),   64'(expReq));
    checkOutput({name, ".stable"},     64'(unstable), 64'd0);
    checkOutput({name, ".loadValid"},  64'(lvCnt),    64'(expLv));
    checkOutput({name, ".busErr"},     64'(beCnt),    64'(expBe));
    if (expLv) begin
      checkOutput({name, ".loadData"}, lvData, rd);
      checkOutput({name, ".lvCycle"},  64'(lvAt), 64'(expHold));
    end
    if (expBe) begin
      checkOutput({name, ".errData"},  beData, 64'd0);
      checkOutput({name, ".errCycle"}, 64'(beAt), 64'(expHold));
    end
    for (int i = 0; i < expGnt && i < gntCnt && i < 4; i++) begin
      checkOutput({name, ".reqAddr"},  gAddr[i], addr);
      checkOutput({name, ".reqWe"},    64'(gWe[i]), (i == 0) ? 64'(kind == K_STORE) : 64'd1);
      checkOutput({name, ".reqWdata"}, gWd[i], (i == 0) ? wd : awd);
      checkOutput({name, ".reqCach"},  64'(gCach[i]), 64'(cach));
    end
  endtask

  // Asserts reset asynchronously while a load is waiting in RESP.
  task automatic resetInResp();
    @(negedge clk);
    memValid = 1'b1; isLoad = 1'b1; isStore = 1'b0; isAmo = 1'b0; isFailSc = 1'b0;
    isCacheMem = 1'b1; memAddr = 64'h0000_0000_8000_2040; memWdata = 64'h1234; flushMem = 1'b0;
    @(negedge clk);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    #1;
    checkOutput("rst.holdBefore", 64'(hold), 64'd1);
    #1;
    rstn = 1'b1;
    #1;
    checkOutput("rst.hold",      64'(hold),               64'd0);
    checkOutput("rst.req",       64'(bus.dmem_req),       64'd0);
    checkOutput("rst.addr",      bus.dmem_addr,           64'd0);
    checkOutput("rst.cacheable", 64'(bus.dmem_cacheable), 64'd0);
    checkOutput("rst.loadData",  loadData,                64'd0);
    checkOutput("rst.loadValid", 64'(loadValid),          64'd0);
    checkOutput("rst.busErr",    64'(busErr),             64'd0);
    memValid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst.idleHold", 64'(hold), 64'd0);
    checkOutput("rst.idleReq",  64'(bus.dmem_req), 64'd0);
  endtask

  initial begin
    int kind, gDly, rDly, fAt, r;
    rstn = 1'b1;
    memValid = 1'b0; isLoad = 1'b0; isStore = 1'b0; isAmo = 1'b0; isFailSc = 1'b0;
    isCacheMem = 1'b0; flushMem = 1'b0; memAddr = '0; memWdata = '0; amoWdata = '0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.hold",      64'(hold),         64'd0);
    checkOutput("reset.req",       64'(bus.dmem_req), 64'd0);
    checkOutput("reset.loadValid", 64'(loadValid),    64'd0);
    checkOutput("reset.busErr",    64'(busErr),       64'd0);
    checkOutput("reset.loadData",  loadData,          64'd0);
    rstn = 1'b0;

    applyStimulus("t1.load",   K_LOAD,   1'b1, 64'h8000_1000, 64'h0, 64'h0, 64'hDEAD_BEEF, 0, 0, -1);
    applyStimulus("t2.store",  K_STORE,  1'b0, 64'h8000_1008, 64'h55, 64'h0, 64'h0, 4, 1, -1);
    applyStimulus("t3.amo",    K_AMO,    1'b1, 64'h8000_2000, 64'h3, 64'd10, 64'd7, 0, 0, -1);
    applyStimulus("t4.failsc", K_FAILSC, 1'b1, 64'h8000_3000, 64'h9, 64'h0, 64'h0, 0, 0, -1);
    applyStimulus("t5.flushPre",  K_LOAD, 1'b1, 64'h8000_4000, 64'h0, 64'h0, 64'hAA, 3, 0, 2);
    applyStimulus("t5.flushPost", K_LOAD, 1'b1, 64'h8000_4008, 64'h0, 64'h0, 64'hBB, 1, 3, 3);
    applyStimulus("t5.flushAmo",  K_AMO,  1'b0, 64'h8000_4010, 64'h1, 64'h22, 64'hCC, 0, 2, 2);
    applyStimulus("t6.timeout",   K_LOAD, 1'b1, 64'h8000_5000, 64'h0, 64'h0, 64'hEE, NEVER, 0, -1);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      kind = (r < 4) ? K_LOAD : (r < 6) ? K_STORE : (r < 9) ? K_AMO : K_FAILSC;
      gDly = $urandom_range(0, 4);
      rDly = $urandom_range(0, 3);
      fAt = -1;
      if (kind != K_FAILSC && $urandom_range(0, 3) == 0)
        fAt = $urandom_range(1, expHoldOf(kind, gDly, rDly) - 1);
      applyStimulus("rand", kind, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, gDly, rDly, fAt);
    end

    resetInResp();
    applyStimulus("t7.recover", K_LOAD, 1'b0, 64'h8000_6000, 64'h0, 64'h0, 64'h1357_9BDF, 1, 1, -1);

    @(negedge clk);
    memValid = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
